// File: rtl/conv_pkg.sv
// Shared types and helpers for the image-BRAM to convolutor sequencer.
// Default geometry lives here; the top derives its own sizes from its parameters.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } conv_state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

  localparam int N_DEF        = 4;
  localparam int K_DEF        = 3;
  localparam int RD_LAT_DEF   = 1;
  localparam int CONV_LAT_DEF = 1;
  localparam int NUM_PIX      = N_DEF * N_DEF;
  localparam int OUT_DIM      = N_DEF - K_DEF + 1;
  localparam int PIPE_LAT     = RD_LAT_DEF + CONV_LAT_DEF;

endpackage

// File: rtl/conv_tag_pipe.sv
// Shift register carrying {vld, row, col} for each issued read alongside the
// BRAM and convolutor latency; the whole chain freezes when en is low.
module conv_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int TAP   = 1,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_vld,
  input  logic [IDX_W-1:0] in_r,
  input  logic [IDX_W-1:0] in_c,
  output logic             tap_vld,
  output logic             inflight,
  output logic             out_vld,
  output logic [IDX_W-1:0] out_r,
  output logic [IDX_W-1:0] out_c
);

  // Element i holds the tag i+1 enabled cycles after its read was issued.
  logic [DEPTH-1:0] vld_q;
  logic [IDX_W-1:0] r_q [DEPTH];
  logic [IDX_W-1:0] c_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else if (en) begin
      vld_q  <= {vld_q[DEPTH-2:0], in_vld};
      r_q[0] <= in_r;
      c_q[0] <= in_c;
      for (int i = 1; i < DEPTH; i++) begin
        r_q[i] <= r_q[i-1];
        c_q[i] <= c_q[i-1];
      end
    end
  end

  assign tap_vld  = vld_q[TAP-1];
  // Everything except the final stage; the final stage is judged via out_valid.
  assign inflight = |vld_q[DEPTH-2:0];
  assign out_vld  = vld_q[DEPTH-1];
  assign out_r    = r_q[DEPTH-1];
  assign out_c    = c_q[DEPTH-1];

endmodule

// File: rtl/conv_scheduler.sv
// Streams one N x N frame from the image BRAM in raster order, drives the
// convolutor enable and flags only the legal window positions downstream.
module conv_scheduler
  import conv_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int K_SIZE   = K_DEF,
  parameter int ADDR_W   = 14,
  parameter int RD_LAT   = RD_LAT_DEF,
  parameter int CONV_LAT = CONV_LAT_DEF,
  parameter int IDX_W    = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              conv_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_row,
  output logic [IDX_W-1:0]  out_col,
  output conv_state_e       state_dbg
);

  localparam int PIX_CNT = N * N;
  localparam int PIX_W   = (clog2(PIX_CNT) < 1) ? 1 : clog2(PIX_CNT);
  localparam int LAT     = RD_LAT + CONV_LAT;

  localparam logic [IDX_W-1:0] KM1    = IDX_W'(K_SIZE - 1);
  localparam logic [IDX_W-1:0] LAST_C = IDX_W'(N - 1);
  localparam logic [PIX_W-1:0] LAST_P = PIX_W'(PIX_CNT - 1);

  conv_state_e      state;
  logic [PIX_W-1:0] p;
  logic [IDX_W-1:0] r;
  logic [IDX_W-1:0] c;

  logic             stall;
  logic             issue;
  logic             tap_vld;
  logic             inflight;
  logic             fin_vld;
  logic [IDX_W-1:0] fin_r;
  logic [IDX_W-1:0] fin_c;

  // Handshake: a result transfers on out_valid & out_ready; an unaccepted
  // result freezes reads, the tag chain, the counters and the output tags.
  assign stall = out_valid & ~out_ready;
  assign issue = (state == RUN) & ~stall;

  assign mem_en    = issue;
  assign mem_addr  = ADDR_W'(p);
  assign conv_en   = tap_vld & ~stall;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  // Wrap-around windows (row or col too small) travel through but are never flagged.
  assign out_valid = fin_vld & (fin_r >= KM1) & (fin_c >= KM1);
  assign out_row   = out_valid ? (fin_r - KM1) : '0;
  assign out_col   = out_valid ? (fin_c - KM1) : '0;

  conv_tag_pipe #(
    .DEPTH (LAT),
    .TAP   (RD_LAT),
    .IDX_W (IDX_W)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .en       (~stall),
    .in_vld   (issue),
    .in_r     (r),
    .in_c     (c),
    .tap_vld  (tap_vld),
    .inflight (inflight),
    .out_vld  (fin_vld),
    .out_r    (fin_r),
    .out_c    (fin_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      p     <= '0;
      r     <= '0;
      c     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            p     <= '0;
            r     <= '0;
            c     <= '0;
          end
        end
        RUN: begin
          if (!stall) begin
            if (p == LAST_P) begin
              state <= DRAIN;
            end else begin
              p <= p + PIX_W'(1);
              if (c == LAST_C) begin
                c <= '0;
                r <= r + IDX_W'(1);
              end else begin
                c <= c + IDX_W'(1);
              end
            end
          end
        end
        DRAIN: begin
          // Final stage leaves this cycle when its result is absent or taken.
          if (!inflight && (!out_valid || out_ready)) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
          p     <= '0;
          r     <= '0;
          c     <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_scheduler.sv
// Bench for conv_scheduler: directed cycle-timing frames plus randomized
// back-pressure frames, checked by a window scoreboard and a timing model.
module tb_conv_scheduler;
  import conv_pkg::*;

  localparam int N   = 4;
  localparam int K   = 3;
  localparam int RD  = 1;
  localparam int LAT = 2;
  localparam int NP  = N * N;
  localparam int OD  = N - K + 1;
  localparam int IW  = 2;
  localparam int AW  = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          out_ready;
  logic          busy, done, mem_en, conv_en, out_valid;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] out_row, out_col;
  conv_state_e   state_dbg;

  // Extra configurations: N=K=3, and deeper BRAM / convolutor latency.
  logic          start_bc;
  logic          busy_b, done_b, mem_en_b, conv_en_b, out_valid_b;
  logic [AW-1:0] mem_addr_b;
  logic [IW-1:0] out_row_b, out_col_b;
  conv_state_e   state_b;
  logic          busy_c, done_c, mem_en_c, conv_en_c, out_valid_c;
  logic [AW-1:0] mem_addr_c;
  logic [IW-1:0] out_row_c, out_col_c;
  conv_state_e   state_c;

  always #5 clk = ~clk;

  conv_scheduler #(.N(N), .K_SIZE(K), .ADDR_W(AW), .RD_LAT(1), .CONV_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_en(mem_en), .mem_addr(mem_addr), .conv_en(conv_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .state_dbg(state_dbg)
  );

  conv_scheduler #(.N(3), .K_SIZE(3), .ADDR_W(AW), .RD_LAT(1), .CONV_LAT(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_bc), .busy(busy_b), .done(done_b),
    .mem_en(mem_en_b), .mem_addr(mem_addr_b), .conv_en(conv_en_b),
    .out_valid(out_valid_b), .out_ready(1'b1),
    .out_row(out_row_b), .out_col(out_col_b), .state_dbg(state_b)
  );

  conv_scheduler #(.N(4), .K_SIZE(3), .ADDR_W(AW), .RD_LAT(2), .CONV_LAT(3)) dut_c (
    .clk(clk), .rst(rst), .start(start_bc), .busy(busy_c), .done(done_c),
    .mem_en(mem_en_c), .mem_addr(mem_addr_c), .conv_en(conv_en_c),
    .out_valid(out_valid_c), .out_ready(1'b1),
    .out_row(out_row_c), .out_col(out_col_c), .state_dbg(state_c)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [2*IW-1:0] exp_q[$];
  int frames_pending = 0;
  int mon_mode = 0;      // 0: scoreboard only, 1: + timing model, 2: + idle/zero check
  int cyc_rel  = 0;
  int s0       = 1 << 20;
  int nstall   = 0;
  bit bc_on    = 1'b0;
  int n_b = 0, nd_b = 0, n_c = 0, nd_c = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc_rel, $time);
    end
  endtask

  // Reference timing: every event after the stall start slips by the stall length.
  function automatic int ev(input int ideal);
    return ideal + ((nstall > 0 && ideal >= s0) ? nstall : 0);
  endfunction

  function automatic int win_ideal(input int i, input int j);
    return 1 + ((i + K - 1) * N + (j + K - 1)) + LAT;
  endfunction

  function automatic int done_ideal();
    return NP + LAT + 1;
  endfunction

  task automatic push_frame();
    for (int i = 0; i < OD; i++)
      for (int j = 0; j < OD; j++)
        exp_q.push_back({IW'(i), IW'(j)});
    frames_pending = frames_pending + 1;
  endtask

  // Scoreboard and timing monitor for the default instance.
  always @(negedge clk) begin
    logic [2*IW-1:0] e;
    bit e_me, e_ce, e_ov, in_stall;
    int e_addr, e_r, e_c, cy;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_row", int'(out_row), int'(e[2*IW-1:IW]));
          check("sb_col", int'(out_col), int'(e[IW-1:0]));
        end
      end
      if (done) begin
        check("done_queue_empty", exp_q.size(), 0);
        check("done_one_frame", frames_pending, 1);
        if (frames_pending > 0) frames_pending = frames_pending - 1;
      end
      if (mon_mode == 1) begin
        cy = cyc_rel;
        e_me = 1'b0; e_ce = 1'b0; e_ov = 1'b0;
        e_addr = 0; e_r = 0; e_c = 0;
        in_stall = (nstall > 0) && (cy >= s0) && (cy < s0 + nstall);
        for (int p = 0; p < NP; p++) begin
          if (ev(1 + p) == cy) begin e_me = 1'b1; e_addr = p; end
          if (ev(1 + p + RD) == cy) e_ce = 1'b1;
        end
        for (int i = 0; i < OD; i++)
          for (int j = 0; j < OD; j++)
            if (ev(win_ideal(i, j)) == cy || (in_stall && win_ideal(i, j) == s0)) begin
              e_ov = 1'b1; e_r = i; e_c = j;
            end
        check("mem_en", int'(mem_en), int'(e_me));
        if (e_me) check("mem_addr", int'(mem_addr), e_addr);
        if (in_stall) check("mem_addr_hold", int'(mem_addr), s0 - 1);
        check("conv_en", int'(conv_en), int'(e_ce));
        check("out_valid", int'(out_valid), int'(e_ov));
        if (e_ov) begin
          check("out_row", int'(out_row), e_r);
          check("out_col", int'(out_col), e_c);
        end
        check("busy", int'(busy), int'(cy >= 1 && cy <= ev(done_ideal())));
        check("done", int'(done), int'(cy == ev(done_ideal())));
      end else if (mon_mode == 2) begin
        check("idle_flags", int'({busy, done, mem_en, conv_en, out_valid}), 0);
        check("idle_addr_tags", int'(mem_addr) + int'(out_row) + int'(out_col), 0);
        check("idle_state", int'(state_dbg), int'(IDLE));
      end
    end
  end

  // Monitors for the alternate configurations, started together with the first frame.
  always @(negedge clk) begin
    if (bc_on && !rst) begin
      if (out_valid_b) begin
        if (n_b == 0) check("b_first_valid_cycle", cyc_rel, 1 + ((3 - 1) * 3 + 3 - 1) + 2);
        check("b_window", int'({out_row_b, out_col_b}), 0);
        n_b++;
      end
      if (done_b) begin
        check("b_done_cycle", cyc_rel, 9 + 2 + 1);
        nd_b++;
      end
      if (out_valid_c) begin
        if (n_c == 0) check("c_first_valid_cycle", cyc_rel, 1 + ((K - 1) * N + K - 1) + 5);
        check("c_row", int'(out_row_c), n_c / OD);
        check("c_col", int'(out_col_c), n_c % OD);
        n_c++;
      end
      if (done_c) begin
        check("c_done_cycle", cyc_rel, NP + 5 + 1);
        nd_c++;
      end
    end
  end

  // One directed frame starting at cycle 0; each call leaves the time at posedge+1.
  task automatic run_frame(input int stall_at, input int stall_len, input bit extra_starts,
                           input bit with_bc, input int ncyc, input int rst_at);
    s0       = (stall_len > 0) ? stall_at : (1 << 20);
    nstall   = stall_len;
    mon_mode = 1;
    bc_on    = with_bc;
    for (int k = 0; k < ncyc; k++) begin
      cyc_rel   = k;
      start     = (k == 0) || (extra_starts && (k == 8 || k == 19));
      start_bc  = with_bc && (k == 0);
      out_ready = !(stall_len > 0 && k >= stall_at && k < stall_at + stall_len);
      if (k == 0) push_frame();
      rst = (k == rst_at);
      if (rst_at >= 0 && k == rst_at + 1) begin
        exp_q.delete();
        frames_pending = 0;
        mon_mode = 2;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; start_bc = 1'b0; out_ready = 1'b1; rst = 1'b0;
    mon_mode = 0; bc_on = 1'b0;
    check("frame_retired", frames_pending, 0);
  endtask

  task automatic random_frame();
    int cnt;
    int gap;
    gap = $urandom_range(0, 3);
    repeat (gap) begin @(posedge clk); #1; end
    start = 1'b1;
    out_ready = ($urandom_range(0, 3) != 0);
    push_frame();
    @(posedge clk); #1;
    cnt = 0;
    while (frames_pending > 0 && cnt < 400) begin
      start     = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      cnt++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("random_frame_done", frames_pending, 0);
    if (frames_pending > 0) begin
      exp_q.delete();
      frames_pending = 0;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_bc = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_mode = 2;
    repeat (2) begin @(posedge clk); #1; end
    mon_mode = 0;

    run_frame(0, 0, 1'b0, 1'b1, 24, -1);
    check("b_window_count", n_b, 1);
    check("b_done_count", nd_b, 1);
    check("c_window_count", n_c, OD * OD);
    check("c_done_count", nd_c, 1);

    run_frame(13, 3, 1'b0, 1'b0, 25, -1);
    run_frame(0, 0, 1'b1, 1'b0, 22, -1);
    run_frame(0, 0, 1'b0, 1'b0, 21, -1);
    run_frame(0, 0, 1'b0, 1'b0, 14, 10);
    run_frame(0, 0, 1'b0, 1'b0, 21, -1);

    for (int f = 0; f < 8; f++) random_frame();

    repeat (3) begin @(posedge clk); #1; end
    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_scheduler.md
Name: conv_scheduler

Overview:
- Sequencer for the image-BRAM → convolutor datapath.
- On a start pulse it streams one N×N frame from the image BRAM, one pixel per cycle in raster order, and drives the convolutor enable.
- It tags each output as valid only for legal window positions (row ≥ K_SIZE-1 and col ≥ K_SIZE-1), so wrap-around windows are never flagged.
- A downstream ready signal back-pressures the whole pipeline. done pulses once the last window has been accepted.

Parameters:
- N, 4, image side length in pixels (N ≥ K_SIZE ≥ 1).
- K_SIZE, 3, kernel side length.
- ADDR_W, 14, image BRAM address width; N*N ≤ 2^ADDR_W.
- RD_LAT, 1, BRAM read latency in enabled cycles (1..2).
- CONV_LAT, 1, convolutor latency from en-with-data to data_o, in enabled cycles.
- IDX_W, $clog2(N) (min 1), width of the row/col tags.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, single-cycle request to process one frame; ignored unless idle.
- busy, out, 1, high from the cycle after start is accepted until done inclusive.
- done, out, 1, one-cycle pulse after the final output is accepted.
- mem_en, out, 1, BRAM enable (ena).
- mem_addr, out, ADDR_W, BRAM address (addra).
- conv_en, out, 1, convolutor enable; BRAM data is valid on this cycle.
- out_valid, out, 1, convolutor data_o is a legal window result.
- out_ready, in, 1, downstream accepts data_o when out_valid & out_ready.
- out_row, out, IDX_W, window top-left row (0..N-K_SIZE), valid with out_valid.
- out_col, out, IDX_W, window top-left column, valid with out_valid.

Behaviour:
- Reset: state=IDLE; busy, done, mem_en, conv_en, out_valid = 0; mem_addr, out_row, out_col = 0; all tag pipelines cleared.
- Reset mid-frame aborts immediately. No done is issued, and the next start begins at address 0.
- stall = out_valid & ~out_ready. While stall is high:
  - mem_en=0 and conv_en=0.
  - mem_addr, the read/conv tag pipeline, the FSM counters, out_valid, out_row and out_col all hold.
  - The BRAM holds douta because ena is low; the convolutor holds because en is low.
- FSM states:
  - IDLE: start=1 → RUN, with pixel counter p=0, r=0, c=0.
  - RUN: each non-stalled cycle asserts mem_en with mem_addr=p, then advances p, with c wrapping at N-1 to c=0, r+1. After issuing p=N*N-1 → DRAIN.
  - DRAIN: no new reads; the pipeline advances while not stalled. Exit to DONE when all tag stages are empty and out_valid is low or accepted this cycle.
  - DONE: done=1 for exactly one cycle → IDLE.
  - busy=1 in RUN, DRAIN and DONE.
- Tag pipeline: each issued read carries {vld, r, c} through RD_LAT stages, then CONV_LAT stages.
  - conv_en = vld at the RD_LAT stage.
  - out_valid = vld & (r ≥ K_SIZE-1) & (c ≥ K_SIZE-1) at the final stage.
  - out_row = r-(K_SIZE-1); out_col = c-(K_SIZE-1).
- Windows per frame = (N-K_SIZE+1)^2, in raster order. With no stall, the first out_valid occurs RD_LAT+CONV_LAT cycles after the read of pixel (K_SIZE-1)*N+K_SIZE-1.
- start during busy is ignored; no queuing.
- start in the same cycle as DONE is ignored.
- K_SIZE=N yields exactly one window, at pixel N*N-1.
- Counters are sized to N*N without overflow. mem_addr is zero-extended to ADDR_W.

Decomposition:
- Package conv_pkg holds:
  - the state enum {IDLE, RUN, DRAIN, DONE};
  - function clog2;
  - localparams NUM_PIX=N*N, OUT_DIM=N-K_SIZE+1, PIPE_LAT=RD_LAT+CONV_LAT.
- One sub-module, conv_tag_pipe: a parameterised-depth shift register of {vld,r,c} with a shared enable (~stall). It exposes the tap at RD_LAT for conv_en and the final stage for output tags.

Test Plan:
Defaults for all cases: N=4, K_SIZE=3, RD_LAT=1, CONV_LAT=1, out_ready=1. start is pulsed at cycle 0.
1. Basic frame:
   - mem_en high on cycles 1-16 with addr 0..15; conv_en high on cycles 2-17.
   - out_valid on cycles 13, 14, 17, 18 with (row,col) = (0,0), (0,1), (1,0), (1,1).
   - done on cycle 19 only; busy on cycles 1-19.
2. Back-pressure: out_ready=0 on cycles 13-15.
   - out_valid stays 1 with (0,0) through cycle 15, and mem_addr holds 12.
   - mem_en and conv_en are 0 on cycles 13-15.
   - Remaining outputs shift +3 cycles; done on cycle 22.
3. start pulsed again at cycle 8 (busy) → ignored. Exactly 4 out_valid and one done occur; a start at cycle 20 runs a second identical frame.
4. rst asserted at cycle 10 → from cycle 11: all outputs 0 and state IDLE, with no done. A new start produces a clean frame from addr 0.
5. N=K_SIZE=3 → a single out_valid with (0,0) on cycle 11; done on cycle 12.
6. RD_LAT=2, CONV_LAT=3, default N/K → the first out_valid moves to cycle 16 and done to cycle 22; out_row/out_col sequence unchanged.
